// File: rtl/fir_out_pkg.sv
// fir_out_pkg: shared FSM state type and default widths for the FIR output
// stage. Imported by fir_out_fifo and fir_out_stage.
package fir_out_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_LEN_W  = 32;
  localparam int PTR_W      = $clog2(DEF_DEPTH);

endpackage

// File: rtl/fir_out_fifo.sv
// fir_out_fifo: synchronous FIFO, registered storage, show-ahead read.
// Ports: clk, rst (sync high), push/din, pop/dout, full, empty.
module fir_out_fifo
  import fir_out_pkg::*;
#(
  parameter int W     = DEF_DATA_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = PTR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  // Flags come from the registered count only, so a pop never
  // frees a slot for a push within the same cycle.
  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Head entry is already a register; zero it while empty so the
  // output bus is quiet out of reset and between frames.
  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/fir_out_stage.sv
// fir_out_stage: buffers FIR results, regenerates tlast from a beat count,
// flags FIR tlast mismatches and pulses done when the frame has drained.
// Ports: axis_clk/axis_rst (sync high); cfg_len/cfg_start; ss_* in from FIR;
// sm_* out to consumer; busy, done, tlast_err, peak.
// Optional: define FIR_OUT_PEAK_EN to track peak |ss_tdata| per frame.
module fir_out_stage
  import fir_out_pkg::*;
#(
  parameter int pDATA_WIDTH = DEF_DATA_W,
  parameter int pDEPTH      = DEF_DEPTH,
  parameter int pLEN_WIDTH  = DEF_LEN_W
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst,
  input  logic [pLEN_WIDTH-1:0]  cfg_len,
  input  logic                   cfg_start,
  input  logic                   ss_tvalid,
  input  logic [pDATA_WIDTH-1:0] ss_tdata,
  input  logic                   ss_tlast,
  output logic                   ss_tready,
  output logic                   sm_tvalid,
  output logic [pDATA_WIDTH-1:0] sm_tdata,
  output logic                   sm_tlast,
  input  logic                   sm_tready,
  output logic                   busy,
  output logic                   done,
  output logic                   tlast_err,
  output logic [pDATA_WIDTH-1:0] peak
);

  localparam int AW = $clog2(pDEPTH);
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE = 1;

  state_t state;
  state_t state_nxt;

  logic [pLEN_WIDTH-1:0] len;
  logic [pLEN_WIDTH-1:0] len_m1;
  logic [pLEN_WIDTH-1:0] in_cnt;
  logic [pLEN_WIDTH-1:0] out_cnt;

  logic full;
  logic empty;
  logic push;
  logic pop;
  logic start_ok;
  logic last_in;
  logic last_out;

  assign len_m1   = len - LEN_ONE;
  assign start_ok = (state == IDLE) && cfg_start;
  assign last_in  = (in_cnt == len_m1);
  assign last_out = (out_cnt == len_m1);

  assign ss_tready = (state == RUN) && !full
                   && (in_cnt < len);
  assign push      = ss_tvalid && ss_tready;
  assign sm_tvalid = !empty;
  assign pop       = sm_tvalid && sm_tready;
  assign sm_tlast  = sm_tvalid && last_out;

  assign busy = (state == RUN) || (state == DRAIN);
  assign done = (state == DONE);

  fir_out_fifo #(
    .W     (pDATA_WIDTH),
    .DEPTH (pDEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk   (axis_clk),
    .rst   (axis_rst),
    .push  (push),
    .din   (ss_tdata),
    .pop   (pop),
    .dout  (sm_tdata),
    .full  (full),
    .empty (empty)
  );

  // Leave RUN on the cycle of the final push, so the final pop
  // (one cycle later at the earliest) is always seen in DRAIN.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (cfg_start) begin
          state_nxt = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (push && last_in) state_nxt = DRAIN;
      end
      DRAIN: begin
        if (pop && last_out) state_nxt = DONE;
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state     <= IDLE;
      len       <= '0;
      in_cnt    <= '0;
      out_cnt   <= '0;
      tlast_err <= 1'b0;
    end else begin
      state <= state_nxt;
      if (start_ok) begin
        len       <= cfg_len;
        in_cnt    <= '0;
        out_cnt   <= '0;
        tlast_err <= 1'b0;
      end else begin
        // ss_tready already caps in_cnt at len.
        if (push) begin
          in_cnt <= in_cnt + LEN_ONE;
          if (ss_tlast != last_in) tlast_err <= 1'b1;
        end
        if (pop && (out_cnt < len)) begin
          out_cnt <= out_cnt + LEN_ONE;
        end
      end
    end
  end

`ifdef FIR_OUT_PEAK_EN
  localparam logic [pDATA_WIDTH-1:0] MIN_NEG =
    {1'b1, {(pDATA_WIDTH-1){1'b0}}};

  logic [pDATA_WIDTH-1:0] mag;

  // Most-negative input has no positive twin; clamp to max.
  always_comb begin
    mag = ss_tdata;
    if (ss_tdata == MIN_NEG) begin
      mag = ~MIN_NEG;
    end else if (ss_tdata[pDATA_WIDTH-1]) begin
      mag = -ss_tdata;
    end
  end

  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      peak <= '0;
    end else if (start_ok) begin
      peak <= '0;
    end else if (push && (mag > peak)) begin
      peak <= mag;
    end
  end
`else
  assign peak = '0;
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// tb_fir_out_stage: randomized scoreboard bench for fir_out_stage.
// Driver queues expected beats; a monitor pops and compares on handshakes.
module tb_fir_out_stage;

  localparam int DW    = 32;
  localparam int DEPTH = 8;
  localparam int LW    = 32;

`ifdef FIR_OUT_PEAK_EN
  localparam bit PEAK_ON = 1'b1;
`else
  localparam bit PEAK_ON = 1'b0;
`endif

  logic          clk;
  logic          rst;
  logic [LW-1:0] cfg_len;
  logic          cfg_start;
  logic          ss_tvalid;
  logic [DW-1:0] ss_tdata;
  logic          ss_tlast;
  logic          ss_tready;
  logic          sm_tvalid;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          sm_tready;
  logic          busy;
  logic          done;
  logic          tlast_err;
  logic [DW-1:0] peak;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  int rdy_mode = 0;
  bit zl_mode = 0;

  logic [DW:0]   exp_q[$];
  logic [DW-1:0] dq[$];

  fir_out_stage #(
    .pDATA_WIDTH (DW),
    .pDEPTH      (DEPTH),
    .pLEN_WIDTH  (LW)
  ) dut (
    .axis_clk  (clk),
    .axis_rst  (rst),
    .cfg_len   (cfg_len),
    .cfg_start (cfg_start),
    .ss_tvalid (ss_tvalid),
    .ss_tdata  (ss_tdata),
    .ss_tlast  (ss_tlast),
    .ss_tready (ss_tready),
    .sm_tvalid (sm_tvalid),
    .sm_tdata  (sm_tdata),
    .sm_tlast  (sm_tlast),
    .sm_tready (sm_tready),
    .busy      (busy),
    .done      (done),
    .tlast_err (tlast_err),
    .peak      (peak)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    checks++;
    failures++;
    $display("FAIL %s actual=timeout required=event", nm);
  endtask

  // |x| of a 32-bit two's complement value, clamped to max positive.
  function automatic longint abs_sat(input logic [31:0] x);
    longint v;
    v = longint'(signed'(x));
    if (v < 0) v = -v;
    if (v > 64'sh7FFFFFFF) v = 64'sh7FFFFFFF;
    return v;
  endfunction

  // Consumer ready: 0 = stalled, 1 = always ready, else random.
  initial begin
    sm_tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       sm_tready = 1'b0;
        1:       sm_tready = 1'b1;
        default: sm_tready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compare each output handshake against the queue head,
  // and require done exactly one cycle after the last beat.
  initial begin : mon
    bit pend;
    logic [DW:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        if (pend) begin
          chk("done_pulse", done, 1);
          pend = 1'b0;
          done_cnt++;
        end else if (done && !zl_mode) begin
          chk("done_unexpected", done, 0);
        end
        if (sm_tvalid && sm_tready) begin
          if (exp_q.size() == 0) begin
            chk("extra_beat", sm_tdata, 0);
          end else begin
            e = exp_q.pop_front();
            chk("sm_tdata", sm_tdata, e[DW-1:0]);
            chk("sm_tlast", sm_tlast, e[DW]);
            if (e[DW]) pend = 1'b1;
          end
        end
      end
    end
  end

  task automatic start(input int n);
    @(posedge clk);
    #1;
    cfg_len   = LW'(n);
    cfg_start = 1'b1;
    @(posedge clk);
    #1;
    cfg_start = 1'b0;
  endtask

  task automatic push_beat(input logic [DW-1:0] d, input logic l,
                           input logic exp_last, input bit allv);
    bit acc;
    int g;
    acc = 1'b0;
    g = 0;
    ss_tdata = d;
    ss_tlast = l;
    while (!acc) begin
      ss_tvalid = allv ? 1'b1 : ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = ss_tvalid && ss_tready;
      if (acc) exp_q.push_back({exp_last, d});
      @(posedge clk);
      #1;
      g++;
      if (!acc && g > 2000) begin
        fail_now("push_timeout");
        acc = 1'b1;
      end
    end
    ss_tvalid = 1'b0;
  endtask

  task automatic run_frame(input int n, input int bad, input bit bp);
    int base;
    int g;
    bit exp_err;
    longint exp_pk;
    logic [DW-1:0] d;
    logic l;
    base = done_cnt;
    exp_err = 1'b0;
    exp_pk = 0;
    start(n);
    @(negedge clk);
    chk("busy_run", busy, 1);
    chk("err_cleared", tlast_err, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < n; i++) begin
      d = (dq.size() > 0) ? dq.pop_front() : DW'($urandom());
      l = (i == n - 1) ^ (i == bad);
      if (i == bad) exp_err = 1'b1;
      if (abs_sat(d) > exp_pk) exp_pk = abs_sat(d);
      if (bp && i == DEPTH) begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("full_ready", ss_tready, 0);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
      end
      push_beat(d, l, i == n - 1, bp);
    end
    g = 0;
    while (done_cnt == base && g < 3000) begin
      @(posedge clk);
      #2;
      g++;
    end
    if (done_cnt == base) fail_now("done_timeout");
    @(negedge clk);
    chk("tlast_err", tlast_err, exp_err);
    chk("busy_idle", busy, 0);
    chk("peak", peak, PEAK_ON ? exp_pk : 0);
    chk("drained", exp_q.size(), 0);
  endtask

  initial begin
    rst       = 1'b1;
    cfg_len   = '0;
    cfg_start = 1'b0;
    ss_tvalid = 1'b0;
    ss_tdata  = '0;
    ss_tlast  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ss_tready", ss_tready, 0);
    chk("rst_sm_tvalid", sm_tvalid, 0);
    chk("rst_sm_tdata", sm_tdata, 0);
    chk("rst_sm_tlast", sm_tlast, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tlast_err", tlast_err, 0);
    chk("rst_peak", peak, 0);
    rst = 1'b0;

    rdy_mode = 1;
    dq = '{32'd10, 32'd20, 32'd30, 32'd40};
    run_frame(4, -1, 1'b0);

    rdy_mode = 0;
    run_frame(12, -1, 1'b1);

    rdy_mode = 2;
    run_frame(3, 1, 1'b0);

    dq = '{32'd5, 32'hFFFF_FFF7, 32'd7};
    run_frame(3, -1, 1'b0);

    dq = '{32'h8000_0000};
    run_frame(1, -1, 1'b0);

    zl_mode = 1'b1;
    start(0);
    @(negedge clk);
    chk("zl_done", done, 1);
    chk("zl_busy", busy, 0);
    chk("zl_ready", ss_tready, 0);
    @(negedge clk);
    chk("zl_done_end", done, 0);
    chk("zl_busy_end", busy, 0);
    zl_mode = 1'b0;

    rdy_mode = 0;
    dq = '{32'h11, 32'h22, 32'hFFFF_0000};
    start(6);
    for (int i = 0; i < 3; i++) begin
      push_beat(dq.pop_front(), 1'b0, 1'b0, 1'b1);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mr_sm_tvalid", sm_tvalid, 0);
    chk("mr_sm_tdata", sm_tdata, 0);
    chk("mr_ss_tready", ss_tready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_peak", peak, 0);
    exp_q.delete();
    rst = 1'b0;
    rdy_mode = 1;
    run_frame(2, -1, 1'b0);

    rdy_mode = 2;
    for (int f = 0; f < 6; f++) begin
      run_frame($urandom_range(1, 20), -1, 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
